serial_addsub: RTL and testbench



---
 rtl/serial_addsub_if.sv | 68 ++++++
 rtl/serial_addsub.sv | 242 ++++++++++++++++++++++++
 tb/tb_serial_addsub.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// ---------------------------------------------------------------------------
// serial_addsub_if
//
// Groups the operand request and result response channels of serial_addsub.
// Both channels use the same valid/ready rule:
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer holds valid (and its payload) until that edge. The consumer
//   may raise or lower ready freely.
//
// Signals:
//   sa_a_in, sa_b_in  operands (W bits)
//   sa_sm2c_sel       1 = sign-magnitude format, 0 = two's complement
//   sa_addsub_sel     0 = A+B, 1 = A-B
//   sa_in_valid       request valid              (requester -> block)
//   sa_in_ready       block can accept operands  (block -> requester)
//   sa_sum_out        registered result (W bits)
//   sa_carry_out      carry (2C) or magnitude overflow (SM)
//   sa_out_valid      result valid               (block -> consumer)
//   sa_out_ready      consumer accepts result    (consumer -> block)
//   sa_state_dbg      current FSM state, observation only
//
// Modports:
//   slave  - the serial_addsub block
//   master - the requester/consumer driving the block
// ---------------------------------------------------------------------------
interface serial_addsub_if #(
    parameter int ADDER_WIDTH = 32
);
    logic [ADDER_WIDTH-1:0] sa_a_in;
    logic [ADDER_WIDTH-1:0] sa_b_in;
    logic                   sa_sm2c_sel;
    logic                   sa_addsub_sel;
    logic                   sa_in_valid;
    logic                   sa_in_ready;
    logic [ADDER_WIDTH-1:0] sa_sum_out;
    logic                   sa_carry_out;
    logic                   sa_out_valid;
    logic                   sa_out_ready;
    logic [2:0]             sa_state_dbg;

    modport slave (
        input  sa_a_in,
        input  sa_b_in,
        input  sa_sm2c_sel,
        input  sa_addsub_sel,
        input  sa_in_valid,
        output sa_in_ready,
        output sa_sum_out,
        output sa_carry_out,
        output sa_out_valid,
        input  sa_out_ready,
        output sa_state_dbg
    );

    modport master (
        output sa_a_in,
        output sa_b_in,
        output sa_sm2c_sel,
        output sa_addsub_sel,
        output sa_in_valid,
        input  sa_in_ready,
        input  sa_sum_out,
        input  sa_carry_out,
        input  sa_out_valid,
        output sa_out_ready,
        input  sa_state_dbg
    );
endinterface

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial adder/subtractor. Accepts one operand pair, computes A+B or A-B
// one bit per clock (LSB first) and presents a registered result. Operands
// and result are either two's complement (2C) or sign-magnitude (SM).
// 2C results are bit-exact with the parallel ripple adder/subtractor.
//
// Parameters:
//   ADDER_WIDTH  operand/result width W (>= 4)
//   SM2C         1 = sign-magnitude support built, 0 = 2C only
//                (sa_sm2c_sel is then treated as 0)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   sa     serial_addsub_if.slave (operand request + result response)
//
// Sequence: IDLE -> PREP (1) -> ADD (N) -> POST (1) -> DONE
//   N = W in 2C mode, W+1 in SM mode. sa_out_valid rises N+2 clocks after
//   the accepting edge. Only one operation is ever in flight.
// ---------------------------------------------------------------------------
module serial_addsub #(
    parameter int ADDER_WIDTH = 32,
    parameter bit SM2C        = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave sa
);

    localparam int W  = ADDER_WIDTH;
    localparam int CW = $clog2(W + 2);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ADD  = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    // Captured request
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sm_q;
    logic          sub_q;

    // Serial datapath: operand shift registers, result shift register and
    // the single carry flop shared by every bit position.
    logic [W:0]    a_sh_q;
    logic [W:0]    b_sh_q;
    logic [W:0]    r_sh_q;
    logic          carry_q;
    logic [CW-1:0] cnt_q;

    // Registered outputs
    logic          in_ready_q;
    logic          out_valid_q;
    logic [W-1:0]  sum_q;
    logic          carry_out_q;

    logic          accept;
    logic [CW-1:0] cnt_last;

    assign accept   = sa.sa_in_valid & in_ready_q;
    // SM mode needs one extra bit so the (W+1)-bit signed sum cannot wrap.
    assign cnt_last = sm_q ? CW'(W) : CW'(W - 1);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)           state_d = PREP;
            PREP:                       state_d = ADD;
            ADD:  if (cnt_q == cnt_last) state_d = POST;
            POST:                       state_d = DONE;
            DONE: if (sa.sa_out_ready)  state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand preparation (evaluated while in PREP)
    // 2C: invert B and inject carry-in for subtraction.
    // SM: turn each sign/magnitude pair into a W-bit 2C value, then sign
    //     extend to W+1. A zero magnitude forces a positive sign so -0 acts
    //     as +0.
    // -----------------------------------------------------------------------
    logic [W-2:0] a_mag;
    logic [W-2:0] b_mag;
    logic         a_neg;
    logic         b_neg;
    logic [W-1:0] a_2c;
    logic [W-1:0] b_2c;
    logic [W:0]   prep_a;
    logic [W:0]   prep_b;
    logic         prep_c;

    always_comb begin
        a_mag = a_q[W-2:0];
        b_mag = b_q[W-2:0];
        a_neg = a_q[W-1] & (|a_mag);
        b_neg = (b_q[W-1] ^ sub_q) & (|b_mag);
        a_2c  = a_neg ? (~{1'b0, a_mag} + 1'b1) : {1'b0, a_mag};
        b_2c  = b_neg ? (~{1'b0, b_mag} + 1'b1) : {1'b0, b_mag};
        if (sm_q) begin
            prep_a = {a_2c[W-1], a_2c};
            prep_b = {b_2c[W-1], b_2c};
            prep_c = 1'b0;
        end else begin
            // Top bit is never shifted through the adder in 2C mode.
            prep_a = {1'b0, a_q};
            prep_b = {1'b0, b_q ^ {W{sub_q}}};
            prep_c = sub_q;
        end
    end

    // -----------------------------------------------------------------------
    // One full-adder slice
    // -----------------------------------------------------------------------
    logic fa_sum;
    logic fa_carry;

    always_comb begin
        fa_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        fa_carry = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) |
                   (b_sh_q[0] & carry_q);
    end

    // -----------------------------------------------------------------------
    // Result formatting (evaluated while in POST)
    // Result bits enter r_sh_q at the top, so after W shifts the 2C sum sits
    // in r_sh_q[W:1]; after W+1 shifts the SM sum fills r_sh_q[W:0].
    // SM: magnitude >= 2^(W-1) does not fit and is flagged as overflow on
    // the carry output; the sign is cleared when the visible result is zero.
    // -----------------------------------------------------------------------
    logic         r_neg;
    logic [W:0]   r_mag;
    logic         mag_ovf;
    logic         mag_zero;
    logic [W-1:0] post_sum;
    logic         post_carry;

    always_comb begin
        r_neg    = r_sh_q[W];
        r_mag    = r_neg ? (~r_sh_q + 1'b1) : r_sh_q;
        mag_ovf  = r_mag[W] | r_mag[W-1];
        mag_zero = ~|r_mag[W-2:0];
        if (sm_q) begin
            post_sum   = {r_neg & ~(mag_zero & ~mag_ovf), r_mag[W-2:0]};
            post_carry = mag_ovf;
        end else begin
            post_sum   = r_sh_q[W:1];
            post_carry = carry_q;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            sub_q   <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q   <= sa.sa_a_in;
                        b_q   <= sa.sa_b_in;
                        sm_q  <= SM2C ? sa.sa_sm2c_sel : 1'b0;
                        sub_q <= sa.sa_addsub_sel;
                    end
                end
                PREP: begin
                    a_sh_q  <= prep_a;
                    b_sh_q  <= prep_b;
                    carry_q <= prep_c;
                    r_sh_q  <= '0;
                    cnt_q   <= '0;
                end
                ADD: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    r_sh_q  <= {fa_sum, r_sh_q[W:1]};
                    carry_q <= fa_carry;
                    cnt_q   <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output registers. Handshake flags follow the next state so they change
    // on the same edge the FSM moves; sum/carry only load in POST and hold
    // their value through DONE and the following IDLE.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            if (state_q == POST) begin
                sum_q       <= post_sum;
                carry_out_q <= post_carry;
            end
        end
    end

    assign sa.sa_in_ready  = in_ready_q;
    assign sa.sa_out_valid = out_valid_q;
    assign sa.sa_sum_out   = sum_q;
    assign sa.sa_carry_out = carry_out_q;
    assign sa.sa_state_dbg = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//
// Bench for serial_addsub at W=8. Expected results come from an arithmetic
// model of 2C and sign-magnitude add/subtract; a monitor compares every
// presented result against a queue of expectations pushed at acceptance.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;
    int n_acc  = 0;
    int n_res  = 0;
    bit rand_done = 1'b0;

    logic [W:0] exp_q[$];

    serial_addsub_if #(.ADDER_WIDTH(W)) sa_bus ();

    serial_addsub #(
        .ADDER_WIDTH(W),
        .SM2C       (1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sa   (sa_bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Returns {carry, sum}.
    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic sm, input logic sub);
        longint t;
        int     va, vb, r, mag, low;
        logic   cy, sg;
        if (!sm) begin
            if (sub) t = longint'(a) - longint'(b) + (longint'(1) << W);
            else     t = longint'(a) + longint'(b);
            cy = (t >= (longint'(1) << W));
            return {cy, W'(t)};
        end
        va = int'(a[W-2:0]);
        if (a[W-1]) va = -va;
        vb = int'(b[W-2:0]);
        if (b[W-1] ^ sub) vb = -vb;
        r   = va + vb;
        mag = (r < 0) ? -r : r;
        cy  = (mag >= (1 << (W-1)));
        low = mag % (1 << (W-1));
        sg  = (r < 0) && !(low == 0 && !cy);
        return {cy, sg, (W-1)'(low)};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    // Sampled on the falling edge: what is seen here is what the next
    // rising edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sa_bus.sa_out_valid) begin
                check("in_ready_low_while_out_valid", sa_bus.sa_in_ready, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_result: got sum %0h with no expected entry",
                             sa_bus.sa_sum_out);
                end else begin
                    check("sum", sa_bus.sa_sum_out, exp_q[0][W-1:0]);
                    check("carry", sa_bus.sa_carry_out, exp_q[0][W]);
                    if (sa_bus.sa_out_ready) void'(exp_q.pop_front());
                end
                if (sa_bus.sa_out_ready) n_res++;
            end
            if (sa_bus.sa_in_valid && sa_bus.sa_in_ready) begin
                exp_q.push_back(model(sa_bus.sa_a_in, sa_bus.sa_b_in,
                                      sa_bus.sa_sm2c_sel, sa_bus.sa_addsub_sel));
                n_acc++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+#1; returns at posedge+#1 of the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sm, input logic sub);
        int guard;
        sa_bus.sa_a_in        = a;
        sa_bus.sa_b_in        = b;
        sa_bus.sa_sm2c_sel    = sm;
        sa_bus.sa_addsub_sel  = sub;
        sa_bus.sa_in_valid    = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!sa_bus.sa_in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", guard);
        end
        @(posedge clk);
        #1;
        // Scramble inputs; the captured operands must not follow them.
        sa_bus.sa_in_valid   = 1'b0;
        sa_bus.sa_a_in       = W'($urandom);
        sa_bus.sa_b_in       = W'($urandom);
        sa_bus.sa_sm2c_sel   = 1'($urandom);
        sa_bus.sa_addsub_sel = 1'($urandom);
    endtask

    // Counts rising edges until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!sa_bus.sa_out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm, input logic sub,
                         input logic [W-1:0] exp_sum, input logic exp_cy,
                         input int exp_lat, input string name);
        int lat;
        sa_bus.sa_out_ready = 1'b1;
        send(a, b, sm, sub);
        check({name, "_in_ready_fall"}, sa_bus.sa_in_ready, 0);
        wait_valid(lat);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_sum_lit"}, sa_bus.sa_sum_out, exp_sum);
        check({name, "_carry_lit"}, sa_bus.sa_carry_out, exp_cy);
        @(posedge clk);
        #1;
        check({name, "_out_valid_fall"}, sa_bus.sa_out_valid, 0);
        check({name, "_in_ready_rise"}, sa_bus.sa_in_ready, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int guard;
        sa_bus.sa_a_in        = '0;
        sa_bus.sa_b_in        = '0;
        sa_bus.sa_sm2c_sel    = 1'b0;
        sa_bus.sa_addsub_sel  = 1'b0;
        sa_bus.sa_in_valid    = 1'b0;
        sa_bus.sa_out_ready   = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", sa_bus.sa_in_ready, 1);
        check("rst_out_valid", sa_bus.sa_out_valid, 0);
        check("rst_sum", sa_bus.sa_sum_out, 0);
        check("rst_carry", sa_bus.sa_carry_out, 0);
        check("rst_state_idle", sa_bus.sa_state_dbg, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed 2C and SM cases with hand-computed results
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 10, "2c_add_7f_01");
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 10, "2c_add_ff_01");
        do_op(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 10, "2c_sub_07_05");
        do_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 10, "2c_sub_05_07");
        do_op(8'h85, 8'h03, 1'b1, 1'b0, 8'h82, 1'b0, 11, "sm_add_85_03");
        do_op(8'h83, 8'h03, 1'b1, 1'b0, 8'h00, 1'b0, 11, "sm_add_83_03");
        do_op(8'h7F, 8'hFF, 1'b1, 1'b1, 8'h7E, 1'b1, 11, "sm_sub_7f_ff");
        do_op(8'h80, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 11, "sm_negzero");

        // Backpressure: result held, new requests refused
        sa_bus.sa_out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, 1'b0);
        wait_valid(lat);
        check("bp_latency", lat, 10);
        repeat (5) begin
            @(posedge clk);
            #1;
            sa_bus.sa_in_valid = 1'b1;
            sa_bus.sa_a_in     = W'($urandom);
            sa_bus.sa_b_in     = W'($urandom);
            check("bp_out_valid_held", sa_bus.sa_out_valid, 1);
            check("bp_in_ready_low", sa_bus.sa_in_ready, 0);
            check("bp_sum_held", sa_bus.sa_sum_out, 8'h46);
            check("bp_carry_held", sa_bus.sa_carry_out, 0);
        end
        sa_bus.sa_in_valid  = 1'b0;
        sa_bus.sa_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_out_valid_fall", sa_bus.sa_out_valid, 0);
        check("bp_in_ready_rise", sa_bus.sa_in_ready, 1);

        // Reset during ADD
        send(8'h55, 8'h22, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        n_acc = n_res;
        #1;
        check("mid_rst_out_valid", sa_bus.sa_out_valid, 0);
        check("mid_rst_sum", sa_bus.sa_sum_out, 0);
        check("mid_rst_carry", sa_bus.sa_carry_out, 0);
        check("mid_rst_in_ready", sa_bus.sa_in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_no_result", sa_bus.sa_out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 10, "post_rst_add");

        // Randomized back-to-back with random gaps and backpressure
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    sa_bus.sa_out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        sa_bus.sa_out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        check("drain_queue_empty", exp_q.size(), 0);
        check("results_equal_accepts", n_res, n_acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
